// File: rtl/vga_fb_scheduler_if.sv
// rtl/vga_fb_scheduler_if.sv - writer handshake and framebuffer RAM port bundle
interface vga_fb_scheduler_if #(
   parameter int ADDR_W = 15
);
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_gnt;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic [7:0]        mem_rdata;

   modport master (
      input  wr_req, wr_addr, wr_data, mem_rdata,
      output wr_gnt, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      output wr_req, wr_addr, wr_data, mem_rdata,
      input  wr_gnt, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/vga_fb_scheduler.sv
// rtl/vga_fb_scheduler.sv - VGA timing, framebuffer scanout and single-writer RAM arbitration
module vga_fb_scheduler #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_W      = 15
) (
   input  logic clock_50,
   input  logic reset,
   vga_fb_scheduler_if.master bus,
   output logic [7:0] red_out,
   output logic [7:0] green_out,
   output logic [7:0] blue_out,
   output logic hsync,
   output logic vsync,
   output logic n_blank,
   output logic vgaclock,
   output logic frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [ADDR_W-1:0] LINE_W = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

   logic          pix_en_q, pix_en_d, vgaclock_q, vgaclock_d;
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          n_blank1_q, n_blank1_d, hsync1_q, hsync1_d, vsync1_q, vsync1_d;
   logic          n_blank_q, n_blank_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          active, scan_rd, gnt;
   logic [ADDR_W-1:0] scan_addr;

   function automatic logic [23:0] expand(input logic [7:0] p);
      return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
   endfunction

   assign active    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
   assign scan_rd   = pix_en_q && active;
   assign scan_addr = ADDR_W'(v_cnt_q >> SCALE_SHIFT) * LINE_W + ADDR_W'(h_cnt_q >> SCALE_SHIFT);
   // Gating on reset keeps a held request from being granted while the block is in reset.
   assign gnt       = reset && bus.wr_req && !scan_rd;

   always_comb begin
      pix_en_d   = ~pix_en_q;
      vgaclock_d = pix_en_q;
      h_cnt_d    = h_cnt_q;
      v_cnt_d    = v_cnt_q;
      if (pix_en_q) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
         end else begin
            h_cnt_d = h_cnt_q + HW'(1);
         end
      end
   end

   // Stage 1 captures the decode on the issue cycle; stage 2 and the colour load on the
   // following cycle, so every DAC output for a pixel changes together two cycles after issue.
   always_comb begin
      n_blank1_d = n_blank1_q;
      hsync1_d   = hsync1_q;
      vsync1_d   = vsync1_q;
      n_blank_d  = n_blank_q;
      hsync_d    = hsync_q;
      vsync_d    = vsync_q;
      rgb_d      = rgb_q;
      if (pix_en_q) begin
         n_blank1_d = active;
         hsync1_d   = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
         vsync1_d   = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
      end else begin
         n_blank_d = n_blank1_q;
         hsync_d   = hsync1_q;
         vsync_d   = vsync1_q;
         rgb_d     = n_blank1_q ? expand(bus.mem_rdata) : 24'h0;
      end
   end

   always_ff @(posedge clock_50 or negedge reset) begin
      if (!reset) begin
         pix_en_q   <= 1'b0;
         vgaclock_q <= 1'b0;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         n_blank1_q <= 1'b0;
         hsync1_q   <= 1'b1;
         vsync1_q   <= 1'b1;
         n_blank_q  <= 1'b0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         rgb_q      <= '0;
      end else begin
         pix_en_q   <= pix_en_d;
         vgaclock_q <= vgaclock_d;
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         n_blank1_q <= n_blank1_d;
         hsync1_q   <= hsync1_d;
         vsync1_q   <= vsync1_d;
         n_blank_q  <= n_blank_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         rgb_q      <= rgb_d;
      end
   end

   assign bus.wr_gnt    = gnt;
   assign bus.mem_we    = gnt;
   assign bus.mem_addr  = scan_rd ? scan_addr : (gnt ? bus.wr_addr : '0);
   assign bus.mem_wdata = gnt ? bus.wr_data : 8'h00;
   assign red_out       = rgb_q[23:16];
   assign green_out     = rgb_q[15:8];
   assign blue_out      = rgb_q[7:0];
   assign hsync         = hsync_q;
   assign vsync         = vsync_q;
   assign n_blank       = n_blank_q;
   assign vgaclock      = vgaclock_q;
   assign frame_start   = pix_en_q && (h_cnt_q == '0) && (v_cnt_q == '0);
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb/tb_vga_fb_scheduler.sv - directed self-checking bench for vga_fb_scheduler (15-line frame)
module tb_vga_fb_scheduler;
   logic clock_50, reset;
   logic [7:0] red_out, green_out, blue_out;
   logic hsync, vsync, n_blank, vgaclock, frame_start;
   logic [7:0] ram [0:32767];
   int k, n_assert, n_fail;

   vga_fb_scheduler_if #(.ADDR_W(15)) bus();

   vga_fb_scheduler #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut (
      .clock_50(clock_50), .reset(reset), .bus(bus),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .hsync(hsync), .vsync(vsync), .n_blank(n_blank),
      .vgaclock(vgaclock), .frame_start(frame_start)
   );

   initial clock_50 = 1'b0;
   always #10 clock_50 = ~clock_50;

   always @(posedge clock_50) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   function automatic int hpos(input int p); return p % 800; endfunction
   function automatic int vpos(input int p); return (p / 800) % 15; endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_50);
      k++;
      #2;
   endtask

   task automatic tick_to(input int n);
      while (k < n) tick();
   endtask

   initial begin
      bit pe, exp_fs, exp_nb, exp_hs, exp_vs, exp_gnt;
      int p, t, q, fs_cnt, fs_k0, fs_k1, n_gnt;
      int err_hs, err_vs, err_nb, err_vc, err_fs, err_addr, err_rgb, err_gnt, err_we, err_wr;
      int cnt_nb, cnt_hs, cnt_vs;
      {fs_cnt, fs_k0, fs_k1, n_gnt, cnt_nb, cnt_hs, cnt_vs} = '0;
      {err_hs, err_vs, err_nb, err_vc, err_fs, err_addr, err_rgb, err_gnt, err_we, err_wr} = '0;
      n_assert = 0; n_fail = 0; k = 0;
      for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
      ram[0] = 8'hE0;
      ram[159] = 8'h03;
      reset = 1'b0;
      bus.wr_req = 1'b1; bus.wr_addr = 15'h0; bus.wr_data = 8'h00;

      // reset state with a request pending
      tick(); tick(); #1;
      chk("rst_wr_gnt", bus.wr_gnt, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_rgb", {red_out, green_out, blue_out}, 0);
      chk("rst_syncs", {hsync, vsync, n_blank}, 3'b110);
      chk("rst_vgaclock", vgaclock, 0);
      chk("rst_frame_start", frame_start, 0);
      bus.wr_req = 1'b0;

      // one full frame plus the start of the next, no writes
      reset = 1'b1; k = 0; #1;
      chk("k0_vgaclock", vgaclock, 0);
      chk("k0_frame_start", frame_start, 0);
      tick();
      while (k <= 24010) begin
         pe = k[0];
         exp_fs = pe && (((k - 1) / 2) % 12000 == 0);
         if (frame_start !== exp_fs) err_fs++;
         if (frame_start) begin
            if (fs_cnt == 0) fs_k0 = k; else fs_k1 = k;
            fs_cnt++;
         end
         if (vgaclock !== !pe) err_vc++;
         if (pe) begin
            p = (k - 1) / 2;
            if (hpos(p) < 640 && vpos(p) < 8)
               if (bus.mem_addr !== 15'((vpos(p) / 4) * 160 + hpos(p) / 4) || bus.mem_we !== 1'b0)
                  err_addr++;
         end
         if (k >= 3) begin
            t = pe ? k - 2 : k - 3;
            q = (t - 1) / 2;
            exp_nb = hpos(q) < 640 && vpos(q) < 8;
            exp_hs = !(hpos(q) >= 656 && hpos(q) <= 751);
            exp_vs = !(vpos(q) == 10 || vpos(q) == 11);
         end else begin
            exp_nb = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
         end
         if (n_blank !== exp_nb) err_nb++;
         if (hsync !== exp_hs) err_hs++;
         if (vsync !== exp_vs) err_vs++;
         if (!n_blank && {red_out, green_out, blue_out} !== 24'h0) err_rgb++;
         if (k >= 3 && k <= 24002) begin
            cnt_nb += int'(n_blank);
            cnt_hs += int'(!hsync);
            cnt_vs += int'(!vsync);
         end
         case (k)
            2:    chk("latency_k2_red", red_out, 8'h00);
            3:    chk("pix0_rgb", {red_out, green_out, blue_out}, 24'hFF0000);
            9:    chk("pix3_red", red_out, 8'hFF);
            11:   chk("pix4_rgb", {n_blank, red_out, green_out, blue_out}, {1'b1, 24'h0});
            1275: chk("pix636_rgb", {red_out, green_out, blue_out}, 24'h0000FF);
            1281: chk("pix639_rgb", {red_out, green_out, blue_out}, 24'h0000FF);
            1283: chk("pix640_blank", {n_blank, blue_out}, 9'h0);
            1603: chk("line1_pix0_red", red_out, 8'hFF);
            6403: chk("line4_pix0_red", red_out, 8'h00);
            default: ;
         endcase
         tick();
      end
      chk("hsync_timing", err_hs, 0);
      chk("vsync_timing", err_vs, 0);
      chk("n_blank_timing", err_nb, 0);
      chk("vgaclock_phase", err_vc, 0);
      chk("frame_start_pulse", err_fs, 0);
      chk("scan_addr", err_addr, 0);
      chk("blank_rgb_zero", err_rgb, 0);
      chk("n_blank_count", cnt_nb, 10240);
      chk("hsync_low_count", cnt_hs, 2880);
      chk("vsync_low_count", cnt_vs, 3200);
      chk("frame_start_period", fs_k1 - fs_k0, 24000);

      // request held through active video
      bus.wr_req = 1'b1; bus.wr_addr = 15'(16'h1234); bus.wr_data = 8'h1C;
      for (int i = 0; i < 200; i++) begin
         #1;
         exp_gnt = !k[0];
         if (bus.wr_gnt !== exp_gnt) err_gnt++;
         if (bus.mem_we !== bus.wr_gnt) err_we++;
         if (bus.wr_gnt === 1'b1) begin
            n_gnt++;
            if (bus.mem_addr !== 15'h1234 || bus.mem_wdata !== 8'h1C) err_wr++;
         end
         tick();
      end
      chk("held_gnt_phase", err_gnt, 0);
      chk("held_we_vs_gnt", err_we, 0);
      chk("held_wr_payload", err_wr, 0);
      chk("held_gnt_count", n_gnt, 100);

      // asynchronous reset mid-line with the request still pending
      chk("pre_reset_n_blank", n_blank, 1);
      reset = 1'b0; #1;
      chk("async_rst_outputs", {hsync, vsync, n_blank, vgaclock, frame_start}, 5'b11000);
      chk("async_rst_rgb", {red_out, green_out, blue_out}, 0);
      chk("async_rst_mem", {bus.wr_gnt, bus.mem_we, bus.mem_addr}, 0);
      tick(); tick(); #1;
      chk("held_rst_gnt", bus.wr_gnt, 0);
      reset = 1'b1; k = 0; #1;
      chk("release_gnt", {bus.wr_gnt, bus.mem_we, bus.mem_addr}, {2'b11, 15'h1234});
      tick();
      bus.wr_req = 1'b0; #1;
      chk("restart_frame_start", frame_start, 1);
      chk("restart_gnt_once", bus.wr_gnt, 0);
      chk("restart_scan_addr", bus.mem_addr, 0);

      // write to address 0 at h_cnt=2 of line 0
      tick_to(3);
      chk("old_pix0_rgb", {red_out, green_out, blue_out}, 24'hFF0000);
      tick_to(5);
      bus.wr_req = 1'b1; bus.wr_addr = 15'h0; bus.wr_data = 8'hFF; #1;
      chk("scan_priority_gnt", {bus.wr_gnt, bus.mem_we}, 2'b00);
      tick(); #1;
      chk("one_cycle_wait_gnt", {bus.wr_gnt, bus.mem_we, bus.mem_wdata}, {2'b11, 8'hFF});
      tick();
      bus.wr_req = 1'b0;
      chk("pix2_before_write", {red_out, green_out}, 16'hFF00);
      tick_to(9);
      chk("pix3_after_write", {red_out, green_out, blue_out}, 24'hFFFFFF);

      // write during horizontal blanking (h_cnt=700)
      tick_to(1401);
      bus.wr_req = 1'b1; bus.wr_addr = 15'h1; bus.wr_data = 8'h1C; #1;
      chk("blank_gnt_same_cycle", {bus.wr_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {2'b11, 15'h1, 8'h1C});
      tick();
      bus.wr_req = 1'b0; #1;
      chk("blank_gnt_dropped", bus.wr_gnt, 0);
      tick_to(1603);
      chk("line1_pix0_white", {red_out, green_out, blue_out}, 24'hFFFFFF);
      tick_to(1611);
      chk("line1_pix4_written", {n_blank, red_out, green_out, blue_out}, {1'b1, 24'h00FF00});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
